// File: rtl/lcd_page_ctrl_if.sv
// Bus between the LCD page sequencer, the mode page generators and the LCD pins.
interface lcd_page_ctrl_if #(
    parameter int unsigned NPAGE = 4
);
    logic                 refresh;
    logic [1:0]           mode_sel;
    logic [8*NPAGE-1:0]   chars_in;
    logic [4:0]           index;
    logic                 lcd_rs;
    logic                 lcd_rw;
    logic                 lcd_e;
    logic [7:0]           lcd_data;
    logic                 busy;
    logic                 init_done;
    logic                 frame_done;

    // Sequencer side
    modport master (
        input  refresh, mode_sel, chars_in,
        output index, lcd_rs, lcd_rw, lcd_e, lcd_data, busy, init_done, frame_done
    );

    // Requester / page-generator / LCD side
    modport slave (
        output refresh, mode_sel, chars_in,
        input  index, lcd_rs, lcd_rw, lcd_e, lcd_data, busy, init_done, frame_done
    );
endinterface

// File: rtl/lcd_page_ctrl.sv
// HD44780-style 2x16 character LCD write sequencer: power-up init, then one
// 34-write frame (2 address commands + 32 chars) per refresh request.
module lcd_page_ctrl #(
    parameter int unsigned NPAGE     = 4,
    parameter int unsigned SETUP     = 2,
    parameter int unsigned E_PULSE   = 12,
    parameter int unsigned CMD_WAIT  = 2000,
    parameter int unsigned CLR_WAIT  = 80000,
    parameter int unsigned INIT_WAIT = 800000,
    parameter int unsigned CHAR_LAT  = 2
) (
    input  logic           clk,
    input  logic           rst,
    lcd_page_ctrl_if.master bus
);
    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    localparam int unsigned MAXW = max2(max2(INIT_WAIT, CLR_WAIT),
                                        max2(CMD_WAIT, max2(E_PULSE, SETUP)));
    localparam int unsigned CW   = $clog2(MAXW + 1);
    localparam int unsigned LW   = $clog2(CHAR_LAT + 2);

    typedef enum logic [2:0] {
        S_PWRUP, S_INIT, S_IDLE, S_ADDR, S_FETCH, S_CHAR, S_NEXT, S_WRITE
    } state_t;

    typedef enum logic [1:0] {W_SETUP, W_PULSE, W_WAIT} wphase_t;

    state_t          state;
    state_t          ret_state;
    wphase_t         wph;
    logic [CW-1:0]   cnt;
    logic [LW-1:0]   lat;
    logic [2:0]      step;
    logic [1:0]      mode_q;
    logic            pending;
    logic [7:0]      char_q;
    logic [4:0]      index_q;
    logic            rs_q;
    logic            e_q;
    logic [7:0]      data_q;
    logic            busy_q;
    logic            init_done_q;
    logic            frame_done_q;

    logic [7:0]      init_cmd_c;
    logic [7:0]      page_char_c;
    logic [CW-1:0]   wait_lim_c;

    assign bus.index      = index_q;
    assign bus.lcd_rs     = rs_q;
    assign bus.lcd_rw     = 1'b0;
    assign bus.lcd_e      = e_q;
    assign bus.lcd_data   = data_q;
    assign bus.busy       = busy_q;
    assign bus.init_done  = init_done_q;
    assign bus.frame_done = frame_done_q;

    // Init command sequence and the post-strobe wait (clear display needs the long one)
    always_comb begin
        init_cmd_c = 8'h01;
        case (step)
            3'd0:    init_cmd_c = 8'h38;
            3'd1:    init_cmd_c = 8'h0C;
            3'd2:    init_cmd_c = 8'h06;
            default: init_cmd_c = 8'h01;
        endcase
        wait_lim_c = (!rs_q && data_q == 8'h01) ? CW'(CLR_WAIT - 1) : CW'(CMD_WAIT - 1);
    end

    // Page mux; out-of-range page selections display blanks
    always_comb begin
        page_char_c = 8'h20;
        for (int unsigned p = 0; p < NPAGE; p++) begin
            if (mode_q == 2'(p)) page_char_c = bus.chars_in[8*p +: 8];
        end
    end

    // Sequencer FSM with embedded shared write-cycle engine
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_PWRUP;
            ret_state    <= S_PWRUP;
            wph          <= W_SETUP;
            cnt          <= '0;
            lat          <= '0;
            step         <= '0;
            mode_q       <= '0;
            pending      <= 1'b0;
            char_q       <= 8'h00;
            index_q      <= '0;
            rs_q         <= 1'b0;
            e_q          <= 1'b0;
            data_q       <= 8'h00;
            busy_q       <= 1'b1;
            init_done_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            if (lat != LW'(CHAR_LAT)) lat <= lat + LW'(1);
            if (bus.refresh && state != S_IDLE) pending <= 1'b1;

            case (state)
                S_PWRUP: begin
                    if (cnt == CW'(INIT_WAIT - 1)) begin
                        cnt   <= '0;
                        state <= S_INIT;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_INIT: begin
                    if (step == 3'd4) begin
                        init_done_q <= 1'b1;
                        busy_q      <= pending | bus.refresh;
                        state       <= S_IDLE;
                    end else begin
                        rs_q      <= 1'b0;
                        data_q    <= init_cmd_c;
                        step      <= step + 3'd1;
                        ret_state <= S_INIT;
                        wph       <= W_SETUP;
                        cnt       <= '0;
                        state     <= S_WRITE;
                    end
                end
                S_IDLE: begin
                    if (bus.refresh || pending) begin
                        mode_q  <= bus.mode_sel;
                        pending <= 1'b0;
                        index_q <= '0;
                        lat     <= '0;
                        busy_q  <= 1'b1;
                        state   <= S_ADDR;
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                S_ADDR: begin
                    rs_q      <= 1'b0;
                    data_q    <= (index_q == 5'd16) ? 8'hC0 : 8'h80;
                    ret_state <= S_FETCH;
                    wph       <= W_SETUP;
                    cnt       <= '0;
                    state     <= S_WRITE;
                end
                S_FETCH: begin
                    if (lat == LW'(CHAR_LAT)) begin
                        char_q <= page_char_c;
                        state  <= S_CHAR;
                    end
                end
                S_CHAR: begin
                    rs_q      <= 1'b1;
                    data_q    <= char_q;
                    ret_state <= S_NEXT;
                    wph       <= W_SETUP;
                    cnt       <= '0;
                    state     <= S_WRITE;
                end
                S_NEXT: begin
                    lat <= '0;
                    if (index_q == 5'd31) begin
                        frame_done_q <= 1'b1;
                        index_q      <= '0;
                        busy_q       <= pending | bus.refresh;
                        state        <= S_IDLE;
                    end else begin
                        index_q <= index_q + 5'd1;
                        state   <= (index_q == 5'd15) ? S_ADDR : S_FETCH;
                    end
                end
                S_WRITE: begin
                    case (wph)
                        W_SETUP: begin
                            if (cnt == CW'(SETUP - 1)) begin
                                e_q <= 1'b1;
                                cnt <= '0;
                                wph <= W_PULSE;
                            end else begin
                                cnt <= cnt + CW'(1);
                            end
                        end
                        W_PULSE: begin
                            if (cnt == CW'(E_PULSE - 1)) begin
                                e_q <= 1'b0;
                                cnt <= '0;
                                wph <= W_WAIT;
                            end else begin
                                cnt <= cnt + CW'(1);
                            end
                        end
                        W_WAIT: begin
                            if (cnt == wait_lim_c) begin
                                cnt   <= '0;
                                state <= ret_state;
                            end else begin
                                cnt <= cnt + CW'(1);
                            end
                        end
                        default: wph <= W_SETUP;
                    endcase
                end
                default: state <= S_PWRUP;
            endcase
        end
    end
endmodule
